// File: rtl/credit_decrementer_if.sv
// rtl/credit_decrementer_if.sv - credit request/grant and load/clear bus of credit_decrementer
interface credit_decrementer_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dec_valid;
    logic             dec_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             underflow;

    modport master (
        output clr, load, load_val, dec_valid,
        input  dec_ready, out, zero, underflow
    );

    modport slave (
        input  clr, load, load_val, dec_valid,
        output dec_ready, out, zero, underflow
    );
endinterface

// File: rtl/credit_decrementer.sv
// rtl/credit_decrementer.sv - loadable credit down-counter with valid/ready grants
// Optional DECREMENTER_WRAP_EN: grants continue past zero, wrapping with a one-cycle underflow pulse.
module credit_decrementer #(
    parameter int WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  arstn,
    credit_decrementer_if.slave   bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ARMED     = 2'd1;
    localparam logic [1:0] EXHAUSTED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             zero_q;
    logic             underflow_q, underflow_d;
    logic             ready;
    logic             grant;

`ifdef DECREMENTER_WRAP_EN
    assign ready = (state_q == ARMED) || (state_q == EXHAUSTED);
`else
    assign ready = (state_q == ARMED);
`endif

    assign grant = bus.dec_valid && ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
`ifdef DECREMENTER_WRAP_EN
        underflow_d = 1'b0;
`else
        underflow_d = underflow_q;
`endif
        if (bus.clr) begin
            state_d     = IDLE;
            count_d     = '0;
            underflow_d = 1'b0;
        end else if (bus.load) begin
            // A load discards any remaining credit and swallows a same-cycle request.
            count_d = bus.load_val;
            state_d = (bus.load_val != '0) ? ARMED : IDLE;
        end else if (grant) begin
            count_d = count_q - WIDTH'(1);
`ifdef DECREMENTER_WRAP_EN
            if (count_q == '0) begin
                underflow_d = 1'b1;
                state_d     = ARMED;
            end else if (count_q == WIDTH'(1)) begin
                state_d = EXHAUSTED;
            end
`else
            if (count_q == WIDTH'(1)) begin
                state_d = EXHAUSTED;
            end
`endif
        end else if (bus.dec_valid) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            zero_q      <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            zero_q      <= (count_d == '0);
            underflow_q <= underflow_d;
        end
    end

    assign bus.dec_ready = ready;
    assign bus.out       = count_q;
    assign bus.zero      = zero_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_credit_decrementer.sv
// tb/tb_credit_decrementer.sv - randomized and directed checks of credit_decrementer against a budget model
module tb_credit_decrementer;
    localparam int WIDTH = 8;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic aclk  = 1'b0;
    logic arstn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    int m_out;
    bit m_active;
    bit m_uf;

    credit_decrementer_if #(.WIDTH(WIDTH)) bus ();

    credit_decrementer #(.WIDTH(WIDTH)) dut (
        .aclk  (aclk),
        .arstn (arstn),
        .bus   (bus)
    );

    always #5 aclk = ~aclk;

    function automatic bit m_ready();
`ifdef DECREMENTER_WRAP_EN
        return m_active;
`else
        return m_active && (m_out != 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"}, 32'(bus.out), 32'(m_out));
        chk({tag, ".zero"}, 32'(bus.zero), 32'(m_out == 0));
        chk({tag, ".ready"}, 32'(bus.dec_ready), 32'(m_ready()));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_uf));
    endtask

    task automatic model_reset();
        m_out    = 0;
        m_active = 0;
        m_uf     = 0;
    endtask

    task automatic step(input bit c, input bit l, input int lv, input bit dv, input string tag);
        bit rdy;
        bus.clr       = c;
        bus.load      = l;
        bus.load_val  = WIDTH'(lv);
        bus.dec_valid = dv;
        rdy = m_ready();
        @(posedge aclk);
        if (c) begin
            model_reset();
        end else if (l) begin
            m_out    = lv;
            m_active = (lv != 0);
`ifdef DECREMENTER_WRAP_EN
            m_uf = 0;
`endif
        end else if (dv && rdy) begin
`ifdef DECREMENTER_WRAP_EN
            m_uf  = (m_out == 0);
            m_out = (m_out == 0) ? MAXV : m_out - 1;
`else
            m_out = m_out - 1;
`endif
        end else if (dv) begin
            m_uf = 1;
        end else begin
`ifdef DECREMENTER_WRAP_EN
            m_uf = 0;
`endif
        end
        #1;
        chk_model(tag);
    endtask

    initial begin
        bus.clr = 0; bus.load = 0; bus.load_val = '0; bus.dec_valid = 0;
        model_reset();

        #100;
        chk("rst.out", 32'(bus.out), 0);
        chk("rst.zero", 32'(bus.zero), 1);
        chk("rst.ready", 32'(bus.dec_ready), 0);
        chk("rst.underflow", 32'(bus.underflow), 0);
        @(negedge aclk);
        arstn = 1;

        step(0, 1, 3, 0, "drain.load");
        chk("drain.out3", 32'(bus.out), 3);
        step(0, 0, 0, 1, "drain.g1");
        chk("drain.out2", 32'(bus.out), 2);
        step(0, 0, 0, 1, "drain.g2");
        step(0, 0, 0, 1, "drain.g3");
        chk("drain.out0", 32'(bus.out), 0);
`ifndef DECREMENTER_WRAP_EN
        chk("drain.ready0", 32'(bus.dec_ready), 0);
        step(0, 0, 0, 1, "drain.req4");
        chk("drain.uf", 32'(bus.underflow), 1);
        chk("drain.out_held", 32'(bus.out), 0);
`endif

        step(1, 0, 0, 0, "zl.clr");
        step(0, 1, 0, 0, "zl.load0");
        chk("zl.ready", 32'(bus.dec_ready), 0);
        chk("zl.zero", 32'(bus.zero), 1);
        step(0, 0, 0, 1, "zl.req");
        chk("zl.uf", 32'(bus.underflow), 1);

        step(1, 0, 0, 0, "col.clr");
        step(0, 1, 5, 0, "col.load5");
        step(0, 1, 9, 1, "col.load9");
        chk("col.out", 32'(bus.out), 9);
        chk("col.uf", 32'(bus.underflow), 0);

        step(0, 1, 7, 0, "clr.load7");
        step(1, 0, 0, 1, "clr.clr");
        chk("clr.out", 32'(bus.out), 0);
        chk("clr.ready", 32'(bus.dec_ready), 0);

        step(0, 1, MAXV, 0, "max.load");
        chk("max.out", 32'(bus.out), MAXV);
        step(0, 0, 0, 1, "max.g");

`ifdef DECREMENTER_WRAP_EN
        step(1, 0, 0, 0, "wrap.clr");
        step(0, 1, 1, 0, "wrap.load1");
        step(0, 0, 0, 1, "wrap.g1");
        chk("wrap.out0", 32'(bus.out), 0);
        chk("wrap.ready", 32'(bus.dec_ready), 1);
        step(0, 0, 0, 1, "wrap.g2");
        chk("wrap.out255", 32'(bus.out), MAXV);
        chk("wrap.uf_pulse", 32'(bus.underflow), 1);
        step(0, 0, 0, 0, "wrap.idle");
        chk("wrap.uf_drop", 32'(bus.underflow), 0);
`endif

        for (int i = 0; i < 400; i++) begin
            bit c, l, dv;
            int lv, sel;
            c   = ($urandom_range(0, 19) == 0);
            l   = ($urandom_range(0, 5) == 0);
            dv  = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 7);
            lv  = (sel == 0) ? 0 : (sel == 1) ? MAXV : $urandom_range(1, 6);
            step(c, l, lv, dv, "rand");
            if (i == 200) begin
                #2 arstn = 0;
                #1;
                model_reset();
                chk_model("async_rst");
                #1 arstn = 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
